// File: rtl/exe_stage_if.sv
// Decode -> execute handoff bus.
// Carries one decoded instruction (operand selects, register numbers,
// register-file read data, immediate, shift amount, PC, destination and
// trap flag) under a de_valid / exe_allowin handshake.
//   master : decode side (drives de_*, reads exe_allowin)
//   slave  : execute side (reads de_*, drives exe_allowin)
interface exe_stage_if #(
  parameter int DATA_WIDTH = 32,
  parameter int RA_W       = 5
);
  logic                  de_valid;
  logic                  exe_allowin;
  logic [3:0]            de_alu_op;
  logic [1:0]            de_src_a_sel;
  logic [1:0]            de_src_b_sel;
  logic [RA_W-1:0]       de_rs;
  logic [RA_W-1:0]       de_rt;
  logic [DATA_WIDTH-1:0] de_rs_val;
  logic [DATA_WIDTH-1:0] de_rt_val;
  logic [15:0]           de_imm16;
  logic [4:0]            de_shamt;
  logic [DATA_WIDTH-1:0] de_pc;
  logic [RA_W-1:0]       de_dest;
  logic                  de_ovf_trap;

  modport master (
    output de_valid, de_alu_op, de_src_a_sel, de_src_b_sel, de_rs, de_rt,
           de_rs_val, de_rt_val, de_imm16, de_shamt, de_pc, de_dest, de_ovf_trap,
    input  exe_allowin
  );

  modport slave (
    input  de_valid, de_alu_op, de_src_a_sel, de_src_b_sel, de_rs, de_rt,
           de_rs_val, de_rt_val, de_imm16, de_shamt, de_pc, de_dest, de_ovf_trap,
    output exe_allowin
  );
endinterface

// File: rtl/exe_stage.sv
// Execute stage of the 5-stage MIPS core (between decode and memory).
// Latches a decoded instruction with its operands already selected and
// forwarded, presents them to an external combinational ALU, and registers
// the ALU result toward the memory stage under a valid/allowin handshake.
// Ports:
//   clk, resetn        clock, asynchronous active-low reset
//   flush              kills EXE and MEM valids, blocks acceptance this cycle
//   de (slave)         decode -> execute instruction bus + exe_allowin
//   fwd_mem_*/fwd_wb_* MEM/WB forwarding sources (dest 0 = none)
//   alu_a/alu_b/alu_op operands and opcode to the ALU
//   alu_result/alu_overflow  ALU response
//   mem_allowin        memory stage can accept
//   mem_valid/mem_result/mem_dest/mem_pc/mem_ovf_exc  registered EXE->MEM payload
module exe_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int RA_W       = 5
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  flush,
  exe_stage_if.slave            de,
  input  logic [RA_W-1:0]       fwd_mem_dest,
  input  logic [RA_W-1:0]       fwd_wb_dest,
  input  logic [DATA_WIDTH-1:0] fwd_mem_val,
  input  logic [DATA_WIDTH-1:0] fwd_wb_val,
  input  logic                  fwd_mem_valid,
  input  logic                  fwd_wb_valid,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  output logic [3:0]            alu_op,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic                  alu_overflow,
  input  logic                  mem_allowin,
  output logic                  mem_valid,
  output logic [DATA_WIDTH-1:0] mem_result,
  output logic [RA_W-1:0]       mem_dest,
  output logic [DATA_WIDTH-1:0] mem_pc,
  output logic                  mem_ovf_exc
);

  // Operand resolution: MEM beats WB beats register file; $0 is never forwarded.
  function automatic logic [DATA_WIDTH-1:0] fwd_operand(
    input logic [RA_W-1:0]       src,
    input logic [DATA_WIDTH-1:0] rf_val,
    input logic                  m_valid,
    input logic [RA_W-1:0]       m_dest,
    input logic [DATA_WIDTH-1:0] m_val,
    input logic                  w_valid,
    input logic [RA_W-1:0]       w_dest,
    input logic [DATA_WIDTH-1:0] w_val
  );
    logic [DATA_WIDTH-1:0] r;
    r = rf_val;
    if (src != '0) begin
      if (m_valid && (m_dest == src))      r = m_val;
      else if (w_valid && (w_dest == src)) r = w_val;
    end
    return r;
  endfunction

  // Single-cycle ALU: an instruction in EXE is always ready to leave.
  logic exe_ready_go;
  logic exe_allowin;
  logic exe_accept;
  logic exe_to_mem;

  logic [DATA_WIDTH-1:0] rs_fwd, rt_fwd;
  logic [DATA_WIDTH-1:0] src_a_sel, src_b_sel;

  logic                  exe_valid_q,    exe_valid_d;
  logic [3:0]            exe_alu_op_q,   exe_alu_op_d;
  logic [DATA_WIDTH-1:0] exe_a_q,        exe_a_d;
  logic [DATA_WIDTH-1:0] exe_b_q,        exe_b_d;
  logic [RA_W-1:0]       exe_dest_q,     exe_dest_d;
  logic [DATA_WIDTH-1:0] exe_pc_q,       exe_pc_d;
  logic                  exe_ovf_trap_q, exe_ovf_trap_d;

  logic                  mem_valid_q,    mem_valid_d;
  logic [DATA_WIDTH-1:0] mem_result_q,   mem_result_d;
  logic [RA_W-1:0]       mem_dest_q,     mem_dest_d;
  logic [DATA_WIDTH-1:0] mem_pc_q,       mem_pc_d;
  logic                  mem_ovf_exc_q,  mem_ovf_exc_d;

  assign exe_ready_go   = 1'b1;
  assign exe_allowin    = ~exe_valid_q | (exe_ready_go & mem_allowin);
  assign de.exe_allowin = exe_allowin;
  assign exe_accept     = exe_allowin & de.de_valid & ~flush;
  assign exe_to_mem     = exe_valid_q & exe_ready_go & mem_allowin & ~flush;

  // Decode -> EXE boundary: select and forward operands before latching.
  always_comb begin
    rs_fwd = fwd_operand(de.de_rs, de.de_rs_val, fwd_mem_valid, fwd_mem_dest, fwd_mem_val,
                         fwd_wb_valid, fwd_wb_dest, fwd_wb_val);
    rt_fwd = fwd_operand(de.de_rt, de.de_rt_val, fwd_mem_valid, fwd_mem_dest, fwd_mem_val,
                         fwd_wb_valid, fwd_wb_dest, fwd_wb_val);
    src_a_sel = '0;
    case (de.de_src_a_sel)
      2'd0:    src_a_sel = rs_fwd;
      2'd1:    src_a_sel = {{(DATA_WIDTH-5){1'b0}}, de.de_shamt};
      2'd2:    src_a_sel = de.de_pc;
      default: src_a_sel = '0;
    endcase
    src_b_sel = '0;
    case (de.de_src_b_sel)
      2'd0:    src_b_sel = rt_fwd;
      2'd1:    src_b_sel = {{(DATA_WIDTH-16){de.de_imm16[15]}}, de.de_imm16};
      2'd2:    src_b_sel = {{(DATA_WIDTH-16){1'b0}}, de.de_imm16};
      default: src_b_sel = DATA_WIDTH'(8);
    endcase
  end

  always_comb begin
    exe_valid_d    = exe_valid_q;
    exe_alu_op_d   = exe_alu_op_q;
    exe_a_d        = exe_a_q;
    exe_b_d        = exe_b_q;
    exe_dest_d     = exe_dest_q;
    exe_pc_d       = exe_pc_q;
    exe_ovf_trap_d = exe_ovf_trap_q;
    if (flush)            exe_valid_d = 1'b0;
    else if (exe_allowin) exe_valid_d = de.de_valid;
    if (exe_accept) begin
      exe_alu_op_d   = de.de_alu_op;
      exe_a_d        = src_a_sel;
      exe_b_d        = src_b_sel;
      exe_dest_d     = de.de_dest;
      exe_pc_d       = de.de_pc;
      exe_ovf_trap_d = de.de_ovf_trap;
    end
  end

  // EXE -> MEM boundary: capture ALU response; a trapped add/sub loses its write-back.
  always_comb begin
    mem_valid_d   = mem_valid_q;
    mem_result_d  = mem_result_q;
    mem_dest_d    = mem_dest_q;
    mem_pc_d      = mem_pc_q;
    mem_ovf_exc_d = mem_ovf_exc_q;
    if (flush)            mem_valid_d = 1'b0;
    else if (mem_allowin) mem_valid_d = exe_valid_q & exe_ready_go;
    if (exe_to_mem) begin
      mem_result_d  = alu_result;
      mem_pc_d      = exe_pc_q;
      mem_ovf_exc_d = exe_ovf_trap_q & alu_overflow;
      mem_dest_d    = (exe_ovf_trap_q & alu_overflow) ? '0 : exe_dest_q;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      exe_valid_q    <= 1'b0;
      exe_alu_op_q   <= '0;
      exe_a_q        <= '0;
      exe_b_q        <= '0;
      exe_dest_q     <= '0;
      exe_pc_q       <= '0;
      exe_ovf_trap_q <= 1'b0;
      mem_valid_q    <= 1'b0;
      mem_result_q   <= '0;
      mem_dest_q     <= '0;
      mem_pc_q       <= '0;
      mem_ovf_exc_q  <= 1'b0;
    end else begin
      exe_valid_q    <= exe_valid_d;
      exe_alu_op_q   <= exe_alu_op_d;
      exe_a_q        <= exe_a_d;
      exe_b_q        <= exe_b_d;
      exe_dest_q     <= exe_dest_d;
      exe_pc_q       <= exe_pc_d;
      exe_ovf_trap_q <= exe_ovf_trap_d;
      mem_valid_q    <= mem_valid_d;
      mem_result_q   <= mem_result_d;
      mem_dest_q     <= mem_dest_d;
      mem_pc_q       <= mem_pc_d;
      mem_ovf_exc_q  <= mem_ovf_exc_d;
    end
  end

  assign alu_a       = exe_a_q;
  assign alu_b       = exe_b_q;
  assign alu_op      = exe_alu_op_q;
  assign mem_valid   = mem_valid_q;
  assign mem_result  = mem_result_q;
  assign mem_dest    = mem_dest_q;
  assign mem_pc      = mem_pc_q;
  assign mem_ovf_exc = mem_ovf_exc_q;

endmodule
